// File: rtl/seq_pkg.sv
// Shared definitions for the multicycle phase sequencer: state encoding,
// instruction-type and opcode constants, instruction classes and the
// decoder that maps a raw ir_type/opcode pair onto a class.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_RST = 3'd0,
    ST_IF  = 3'd1,
    ST_ID  = 3'd2,
    ST_EX  = 3'd3,
    ST_MEM = 3'd4,
    ST_WB  = 3'd5
  } state_e;

  localparam logic [1:0] IR_R   = 2'b00;
  localparam logic [1:0] IR_I   = 2'b01;
  localparam logic [1:0] IR_J   = 2'b10;
  localparam logic [1:0] IR_ILL = 2'b11;

  localparam logic [3:0] OP_ANDI = 4'b0010;
  localparam logic [3:0] OP_ADDI = 4'b0011;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_BNE  = 4'b0111;
  localparam logic [3:0] OP_FOR  = 4'b1000;

  // CLS_R is the cleared value of the class register
  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_ALUI = 3'd1,
    CLS_LW   = 3'd2,
    CLS_SW   = 3'd3,
    CLS_BR   = 3'd4,
    CLS_J    = 3'd5,
    CLS_ILL  = 3'd6
  } cls_e;

  function automatic cls_e decode_class(input logic [1:0] ir_type, input logic [3:0] opcode);
    cls_e c;
    c = CLS_ILL;
    case (ir_type)
      IR_R: c = CLS_R;
      IR_J: c = CLS_J;
      IR_I: begin
        case (opcode)
          OP_ANDI, OP_ADDI:        c = CLS_ALUI;
          OP_LW:                   c = CLS_LW;
          OP_SW:                   c = CLS_SW;
          OP_BEQ, OP_BNE, OP_FOR:  c = CLS_BR;
          default:                 c = CLS_ILL;
        endcase
      end
      default: c = CLS_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seq_perf_counter.sv
// Free-running performance counters for the sequencer: active cycles and
// retired instructions. Both wrap at 2^32.
module seq_perf_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_cycle_inc,
  input  logic        i_instr_inc,
  output logic [31:0] o_cycle_count,
  output logic [31:0] o_instr_count
);

  logic [31:0] r_cycle_count;
  logic [31:0] r_instr_count;

  // Count enabled non-reset cycles and PC write strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else begin
      if (i_cycle_inc) r_cycle_count <= r_cycle_count + 32'd1;
      if (i_instr_inc) r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign o_cycle_count = r_cycle_count;
  assign o_instr_count = r_instr_count;

endmodule

// File: rtl/multicycle_sequencer.sv
// Phase sequencer for the multicycle datapath. Walks each instruction
// through IF/ID/EX/MEM/WB and issues one-cycle phase enables; pc_update is
// the single PC write strobe. The class of the instruction is captured in
// ID so later phases ignore the instruction-register inputs.
// Optional feature macro: SEQ_PERF_CNT_EN adds cycle_count/instr_count.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  ir_type,
  input  logic [3:0]  opcode,
  input  logic        mem_ready,
  output logic        ir_load,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        pc_update,
  output logic        illegal,
  output logic        timeout,
  output logic [2:0]  phase
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT_MAX);

  state_e      r_state;
  cls_e        r_class;
  logic [3:0]  r_wait;

  state_e      w_state_nxt;
  cls_e        w_class_nxt;
  logic [3:0]  w_wait_nxt;
  cls_e        w_dec_class;
  logic        w_go;
  logic        w_ir_load, w_reg_write, w_mem_read, w_mem_write;
  logic        w_pc_update, w_illegal, w_timeout;

  assign w_dec_class = decode_class(ir_type, opcode);
  // reset outranks everything; en low freezes the machine and mutes strobes
  assign w_go        = en & ~reset;

  // State, class and wait-counter registers; held while en is low
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RST;
      r_class <= CLS_R;
      r_wait  <= '0;
    end else if (en) begin
      r_state <= w_state_nxt;
      r_class <= w_class_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  // Next-state and phase-strobe decode
  always_comb begin
    w_state_nxt = r_state;
    w_class_nxt = r_class;
    w_wait_nxt  = r_wait;
    w_ir_load   = 1'b0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_pc_update = 1'b0;
    w_illegal   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_RST: w_state_nxt = ST_IF;
      ST_IF: begin
        w_ir_load   = 1'b1;
        w_state_nxt = ST_ID;
      end
      ST_ID: begin
        w_class_nxt = w_dec_class;
        case (w_dec_class)
          CLS_J: begin
            w_pc_update = 1'b1;
            w_state_nxt = ST_IF;
          end
          CLS_ILL: begin
            w_pc_update = 1'b1;
            w_illegal   = 1'b1;
            w_state_nxt = ST_IF;
          end
          default: w_state_nxt = ST_EX;
        endcase
      end
      ST_EX: begin
        case (r_class)
          CLS_BR: begin
            w_pc_update = 1'b1;
            w_state_nxt = ST_IF;
          end
          CLS_LW, CLS_SW: w_state_nxt = ST_MEM;
          default:        w_state_nxt = ST_WB;
        endcase
      end
      ST_MEM: begin
        w_mem_read  = (r_class == CLS_LW);
        w_mem_write = (r_class == CLS_SW);
        if (mem_ready) begin
          w_wait_nxt = '0;
          if (r_class == CLS_LW) begin
            w_state_nxt = ST_WB;
          end else begin
            w_pc_update = 1'b1;
            w_state_nxt = ST_IF;
          end
        end else if (r_wait == WAIT_MAX) begin
          // memory never answered: drop the instruction and move on
          w_timeout   = 1'b1;
          w_pc_update = 1'b1;
          w_wait_nxt  = '0;
          w_state_nxt = ST_IF;
        end else begin
          w_wait_nxt = r_wait + 4'd1;
        end
      end
      ST_WB: begin
        w_reg_write = 1'b1;
        w_pc_update = 1'b1;
        w_state_nxt = ST_IF;
      end
      default: w_state_nxt = ST_RST;
    endcase
  end

  assign ir_load   = w_go & w_ir_load;
  assign reg_write = w_go & w_reg_write;
  assign mem_read  = w_go & w_mem_read;
  assign mem_write = w_go & w_mem_write;
  assign pc_update = w_go & w_pc_update;
  assign illegal   = w_go & w_illegal;
  assign timeout   = w_go & w_timeout;
  assign phase     = r_state;

`ifdef SEQ_PERF_CNT_EN
  logic w_cycle_inc;
  assign w_cycle_inc = en & (r_state != ST_RST);

  seq_perf_counter u_perf (
    .clk           (clk),
    .reset         (reset),
    .i_cycle_inc   (w_cycle_inc),
    .i_instr_inc   (pc_update),
    .o_cycle_count (cycle_count),
    .o_instr_count (instr_count)
  );
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer. A reference model expands each
// instruction into the list of cycles it must take (phase, strobes and the
// mem_ready value to present), and the runner replays that list against the
// DUT with optional en stalls, comparing every cycle.
module tb_multicycle_sequencer;

  localparam int K_R = 0, K_ALUI = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_J = 5, K_ILL = 6;
  localparam logic [6:0] S_IL = 7'b1000000, S_RW = 7'b0100000, S_MR = 7'b0010000,
                         S_MW = 7'b0001000, S_PC = 7'b0000100, S_ILG = 7'b0000010,
                         S_TO = 7'b0000001;
  localparam int WAIT_LIMIT = 15;

  typedef struct packed {
    logic [2:0] ph;
    logic [6:0] st;
    logic [5:0] enc;
    logic       mr;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1, en = 1'b0, mem_ready = 1'b0;
  logic [1:0] ir_type = 2'b00;
  logic [3:0] opcode = 4'b0000;
  logic ir_load, reg_write, mem_read, mem_write, pc_update, illegal, timeout;
  logic [2:0] phase;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_count, instr_count;
  logic [31:0] m_cyc = 0, m_ins = 0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  rec_t q[$];

  always #5 clk = ~clk;

  multicycle_sequencer #(.MEM_WAIT_MAX(WAIT_LIMIT)) dut (
    .clk(clk), .reset(reset), .en(en), .ir_type(ir_type), .opcode(opcode),
    .mem_ready(mem_ready), .ir_load(ir_load), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .pc_update(pc_update),
    .illegal(illegal), .timeout(timeout), .phase(phase)
`ifdef SEQ_PERF_CNT_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  function automatic void push(input logic [2:0] ph, input logic [6:0] st,
                               input logic [5:0] enc, input logic mr);
    rec_t r;
    r.ph = ph; r.st = st; r.enc = enc; r.mr = mr;
    q.push_back(r);
  endfunction

  function automatic logic [5:0] rand_enc(input int c);
    logic [3:0] op;
    int k;
    op = 4'($urandom_range(0, 15));
    case (c)
      K_R:    return {2'b00, op};
      K_J:    return {2'b10, op};
      K_ALUI: return {2'b01, 4'($urandom_range(2, 3))};
      K_LW:   return 6'b01_0100;
      K_SW:   return 6'b01_0101;
      K_BR:   return {2'b01, 4'($urandom_range(6, 8))};
      default: begin
        if ($urandom_range(0, 1) == 1) return {2'b11, op};
        k = $urandom_range(0, 8);
        return {2'b01, (k < 2) ? 4'(k) : 4'(k + 7)};
      end
    endcase
  endfunction

  // Expand one instruction of class c into its expected cycles. w is the
  // number of MEM cycles without mem_ready; above the limit it times out.
  function automatic void push_instr(input int c, input int w, input logic [5:0] enc);
    logic [6:0] m;
    push(3'd1, S_IL, enc, 1'b0);
    if (c == K_J) begin
      push(3'd2, S_PC, enc, 1'b0);
    end else if (c == K_ILL) begin
      push(3'd2, S_PC | S_ILG, enc, 1'b0);
    end else begin
      push(3'd2, 7'd0, enc, 1'b0);
      if (c == K_BR) begin
        push(3'd3, S_PC, enc, 1'b0);
      end else if (c == K_R || c == K_ALUI) begin
        push(3'd3, 7'd0, enc, 1'b0);
        push(3'd5, S_RW | S_PC, enc, 1'b0);
      end else begin
        push(3'd3, 7'd0, enc, 1'b0);
        m = (c == K_LW) ? S_MR : S_MW;
        if (w <= WAIT_LIMIT) begin
          for (int i = 0; i < w; i++) push(3'd4, m, enc, 1'b0);
          if (c == K_LW) begin
            push(3'd4, m, enc, 1'b1);
            push(3'd5, S_RW | S_PC, enc, 1'b0);
          end else begin
            push(3'd4, m | S_PC, enc, 1'b1);
          end
        end else begin
          for (int i = 0; i < WAIT_LIMIT; i++) push(3'd4, m, enc, 1'b0);
          push(3'd4, m | S_PC | S_TO, enc, 1'b0);
        end
      end
    end
  endfunction

  // One clock cycle: drive inputs, compare outputs at the falling edge.
  task automatic step(input rec_t r, input logic en_v, input logic rst_v, input string nm);
    logic [9:0] exp_v, act_v;
    en = en_v;
    reset = rst_v;
    if (r.ph == 3'd2) {ir_type, opcode} = r.enc;
    else {ir_type, opcode} = 6'($urandom_range(0, 63));
    mem_ready = en_v ? r.mr : 1'($urandom_range(0, 1));
    @(negedge clk);
    exp_v = {r.ph, (en_v && !rst_v) ? r.st : 7'd0};
    act_v = {phase, ir_load, reg_write, mem_read, mem_write, pc_update, illegal, timeout};
    n_checks++;
    if (act_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s t=%0t: got phase=%0d strobes=%b, want phase=%0d strobes=%b",
               nm, $time, act_v[9:7], act_v[6:0], exp_v[9:7], exp_v[6:0]);
    end
`ifdef SEQ_PERF_CNT_EN
    if (rst_v) begin
      m_cyc = 0; m_ins = 0;
    end else if (en_v) begin
      if (r.ph != 3'd0) m_cyc = m_cyc + 1;
      if (r.st[2]) m_ins = m_ins + 1;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic check_perf(input string nm);
`ifdef SEQ_PERF_CNT_EN
    @(negedge clk);
    n_checks++;
    if (cycle_count !== m_cyc || instr_count !== m_ins) begin
      n_errors++;
      $display("FAIL %s perf: got cyc=%0d ins=%0d, want cyc=%0d ins=%0d",
               nm, cycle_count, instr_count, m_cyc, m_ins);
    end
    @(posedge clk);
    #1;
`else
    if (nm.len() < 0) $display("%s", nm);
`endif
  endtask

  // Replay the expected cycle list; optional 3-cycle stall on a given
  // phase and optional random en drops. Stops after max_n records.
  task automatic run_q(input string nm, input int stall_ph, input bit rand_en, input int max_n);
    int n;
    bit stalled;
    n = 0;
    stalled = 0;
    while (q.size() > 0 && n < max_n) begin
      if (!stalled && int'(q[0].ph) == stall_ph) begin
        stalled = 1;
        repeat (3) step(q[0], 1'b0, 1'b0, nm);
      end
      if (rand_en && $urandom_range(0, 4) == 0) step(q[0], 1'b0, 1'b0, nm);
      step(q[0], 1'b1, 1'b0, nm);
      void'(q.pop_front());
      n++;
    end
  endtask

  // Reset for a few cycles, then the single RST cycle before IF.
  task automatic do_reset(input string nm);
    rec_t r0;
    r0 = '0;
    q.delete();
    reset = 1'b1;
    en = 1'b1;
    @(posedge clk);
    #1;
    step(r0, 1'b1, 1'b1, nm);
    step(r0, 1'b1, 1'b1, nm);
    step(r0, 1'b1, 1'b0, nm);
  endtask

  task automatic test_reset();
    do_reset("reset");
    check_perf("reset");
  endtask

  task automatic test_r_type();
    do_reset("r_type");
    push_instr(K_R, 0, 6'b00_1010);
    run_q("r_type", -1, 0, 1000);
    check_perf("r_type");
  endtask

  task automatic test_lw_wait();
    push_instr(K_LW, 3, 6'b01_0100);
    run_q("lw_wait", -1, 0, 1000);
    push_instr(K_LW, WAIT_LIMIT, 6'b01_0100);
    run_q("lw_ready_at_limit", -1, 0, 1000);
  endtask

  task automatic test_beq_j();
    push_instr(K_BR, 0, 6'b01_0110);
    push_instr(K_J, 0, 6'b10_0011);
    run_q("beq_j", -1, 0, 1000);
  endtask

  task automatic test_illegal();
    push_instr(K_ILL, 0, 6'b01_1111);
    push_instr(K_ILL, 0, 6'b11_0100);
    push_instr(K_R, 0, 6'b00_0000);
    run_q("illegal", -1, 0, 1000);
  endtask

  task automatic test_sw_timeout();
    rec_t r;
    push_instr(K_SW, WAIT_LIMIT + 1, 6'b01_0101);
    run_q("sw_timeout", -1, 0, 1000);
    // IF, ID, EX and four MEM cycles, then reset on MEM cycle 5
    push_instr(K_SW, WAIT_LIMIT + 1, 6'b01_0101);
    run_q("sw_reset_mem", -1, 0, 7);
    q.delete();
    r = '0;
    r.ph = 3'd4; r.st = S_MW | S_PC | S_TO; r.mr = 1'b1;
    step(r, 1'b1, 1'b1, "sw_reset_mem");
    r = '0;
    step(r, 1'b1, 1'b0, "sw_after_reset");
    push_instr(K_SW, 0, 6'b01_0101);
    run_q("sw_recover", -1, 0, 1000);
    check_perf("sw_timeout");
  endtask

  task automatic test_en_stall();
    push_instr(K_ALUI, 0, 6'b01_0011);
    run_q("en_stall", 3, 0, 1000);
    check_perf("en_stall");
  endtask

  task automatic test_random();
    int c, w;
    for (int i = 0; i < 40; i++) begin
      c = $urandom_range(0, 6);
      w = ($urandom_range(0, 5) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
      push_instr(c, w, rand_enc(c));
      run_q("random", -1, 1, 1000);
    end
    check_perf("random");
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_r_type();
    test_lw_wait();
    test_beq_j();
    test_illegal();
    test_sw_timeout();
    test_en_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Phase-sequencing FSM for the multi-cycle datapath. Steps each instruction through IF/ID/EX/MEM/WB using the decoded `ir_type`/`opcode`, and issues one-cycle phase enables (IR load, register write, memory read/write, PC update). It replaces the `clk_cycles`-counting scheme: `pc_update` is the single PC write strobe, qualified by the PC-select logic's `pc_ctrl`. It sits between the instruction register and the PC/register-file/memory write ports.

## Interface
Parameters:
- `MEM_WAIT_MAX`, 15: max cycles in MEM waiting for `mem_ready` before a forced exit with `timeout` pulse.

Ports:
- `clk` input 1: single clock; all state changes on rising edge.
- `reset` input 1: synchronous, active-high.
- `en` input 1: advance enable; when low the FSM holds state and all strobes are 0.
- `ir_type` input 2: 00 R, 01 I, 10 J, 11 illegal.
- `opcode` input 4: I-type opcode (0010 ANDI, 0011 ADDI, 0100 LW, 0101 SW, 0110 BEQ, 0111 BNE, 1000 FOR).
- `mem_ready` input 1: data memory done; sampled only in MEM.
- `ir_load` output 1: load instruction register (IF).
- `reg_write` output 1: register-file write (WB).
- `mem_read` output 1: data read (MEM, LW).
- `mem_write` output 1: data write (MEM, SW).
- `pc_update` output 1: PC write strobe, last phase of instruction.
- `illegal` output 1: one-cycle pulse on undecodable instruction.
- `timeout` output 1: one-cycle pulse on MEM wait overflow.
- `phase` output 3: current state encoding.

## Operation
- States: RST(0), IF(1), ID(2), EX(3), MEM(4), WB(5).
- RST -> IF unconditionally (when `en`).
- IF -> ID; `ir_load`=1. In ID, `ir_type`/`opcode` are latched into an internal class register; later states use only the latched class.
- ID: J-type -> IF with `pc_update`=1 (2 cycles). Illegal (`ir_type`=11, or I-type opcode outside the list) -> IF with `pc_update`=1 and `illegal`=1. All else -> EX.
- EX: BEQ/BNE/FOR -> IF with `pc_update`=1 (3 cycles). R/ANDI/ADDI -> WB. LW/SW -> MEM.
- MEM: `mem_read` (LW) or `mem_write` (SW) is held while waiting. On `mem_ready`=1: LW -> WB; SW -> IF with `pc_update`=1 (4 cycles minimum).
- WB: `reg_write`=1, `pc_update`=1 -> IF. Totals: R/ANDI/ADDI 4 cycles, LW 5 cycles minimum.
- Wait counter (4 bits) counts MEM cycles without `mem_ready`. When it reaches `MEM_WAIT_MAX`: `timeout` pulses, the instruction is abandoned (`pc_update`=1, no `reg_write`), and the FSM goes to IF. The counter clears on leaving MEM.
- Every strobe is a Moore decode of state plus latched class, gated by `en`. At most one of `reg_write`/`mem_write` is high in any cycle.

## Timing
- Reset: state=RST, class register cleared, wait counter 0. All strobes 0 and `phase`=0 in the cycle after reset.
- First `ir_load` comes 1 cycle after `reset` deasserts (with `en`=1).
- `pc_update` is high for exactly one cycle per instruction. The PC register takes the new value on that cycle's closing edge, and IF follows on the next cycle.
- `en` low mid-instruction: state, class and wait counter freeze, and strobes are 0. Resuming continues from the same state with no phase repeated.
- `reset` asserted in any state, including MEM mid-wait, wins over `en` and `mem_ready`. Next state is RST and no strobe fires that cycle.
- `mem_ready` arriving in the same cycle the counter hits `MEM_WAIT_MAX`: `mem_ready` wins and no `timeout` is raised.

## Configuration
- `SEQ_PERF_CNT_EN` defined: adds outputs `cycle_count` [31:0] and `instr_count` [31:0].
  - Both reset to 0 and wrap at 2^32.
  - `cycle_count` increments on every `en` cycle outside RST.
  - `instr_count` increments on every `pc_update`.
- Undefined: those ports and their logic are absent, and the remaining behaviour is identical.

## Structure
- Shared package `seq_pkg`: state encoding, `ir_type` constants, opcode constants, instruction-class enum (R, ALUI, LW, SW, BR, J, ILL).
- Optional sub-module `seq_perf_counter` holds both counters, instantiated only under `SEQ_PERF_CNT_EN`.

## Test plan
- R-type (`ir_type`=00) after reset, `en`=1 -> `phase` 1,2,3,5; `ir_load` at cycle 1, `reg_write`+`pc_update` at cycle 4.
- LW (01/0100) with `mem_ready` low for 3 MEM cycles -> `mem_read` high for 4 cycles, then WB; 8 cycles total.
- BEQ (01/0110) followed by J-type (10) -> `pc_update` at cycle 3, then at cycle 5. Never any `reg_write`/`mem_write`.
- I-type opcode 1111 -> `illegal` and `pc_update` pulse in ID; next `phase`=1.
- SW with `mem_ready` never asserted, `MEM_WAIT_MAX`=15 -> `timeout` plus `pc_update` on MEM cycle 16, no `reg_write`. Repeat with `reset` in MEM cycle 5 -> `phase`=0 next cycle, all strobes 0.
- `en` dropped for 3 cycles during EX of ADDI -> `phase` holds 3 and strobes stay 0; after resume, WB occurs once. With `SEQ_PERF_CNT_EN`, `instr_count` increments by 1.
